// File: rtl/hp48_bus_cfg_mux_pkg.sv
// Shared definitions for the Saturn nibble-bus manager: bus command codes
// and the per-slot configuration states.
package hp48_bus_cfg_mux_pkg;

   localparam logic [3:0] BUSCMD_NOP         = 4'h0;
   localparam logic [3:0] BUSCMD_PC_READ     = 4'h1;
   localparam logic [3:0] BUSCMD_DP_READ     = 4'h2;
   localparam logic [3:0] BUSCMD_DP_WRITE    = 4'h3;
   localparam logic [3:0] BUSCMD_LOAD_PC     = 4'h4;
   localparam logic [3:0] BUSCMD_LOAD_DP     = 4'h5;
   localparam logic [3:0] BUSCMD_CONFIGURE   = 4'h6;
   localparam logic [3:0] BUSCMD_UNCONFIGURE = 4'h7;
   localparam logic [3:0] BUSCMD_RESET       = 4'h8;

   typedef enum logic [1:0] {
      SLOT_UNCFG      = 2'd0,
      SLOT_SIZED      = 2'd1,
      SLOT_CONFIGURED = 2'd2
   } slot_state_t;

endpackage

// File: rtl/hp48_bus_cfg_mux_slot.sv
// One configurable bus slot: two-step CONFIGURE (mask, then base) and the
// address hit compare. A fixed slot reports its parameter mapping instead.
module hp48_bus_slot
   import hp48_bus_cfg_mux_pkg::*;
#(
   parameter int              ADDR_W   = 20,
   parameter bit              FIXED    = 1'b0,
   parameter logic [ADDR_W-1:0] FIX_BASE = '0,
   parameter logic [ADDR_W-1:0] FIX_MASK = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] address,
   input  logic              cfg_wr,
   input  logic              bus_reset,
   output logic              configured,
   output logic              hit
);

   slot_state_t       state_q;
   logic [ADDR_W-1:0] mask_q;
   logic [ADDR_W-1:0] base_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= SLOT_UNCFG;
         mask_q  <= '0;
         base_q  <= '0;
      end else if (bus_reset) begin
         state_q <= SLOT_UNCFG;
         mask_q  <= '0;
         base_q  <= '0;
      end else if (cfg_wr) begin
         case (state_q)
            SLOT_UNCFG: begin
               mask_q  <= address;
               state_q <= SLOT_SIZED;
            end
            SLOT_SIZED: begin
               base_q  <= address & mask_q;
               state_q <= SLOT_CONFIGURED;
            end
            default: state_q <= state_q;
         endcase
      end
   end

   logic [ADDR_W-1:0] eff_mask;
   logic [ADDR_W-1:0] eff_base;
   logic              eff_cfg;

   // A fixed slot ignores its registers entirely, including BUSCMD_RESET.
   assign eff_mask   = FIXED ? FIX_MASK : mask_q;
   assign eff_base   = FIXED ? FIX_BASE : base_q;
   assign eff_cfg    = FIXED ? 1'b1 : (state_q == SLOT_CONFIGURED);
   assign configured = eff_cfg;
   assign hit        = eff_cfg && ((address & eff_mask) == eff_base);

endmodule

// File: rtl/hp48_bus_cfg_mux.sv
// Saturn bus manager: N configurable slots decoded by priority with ROM
// fallback, registered read data, error pulse and configuration status.
module hp48_bus_cfg_mux
   import hp48_bus_cfg_mux_pkg::*;
#(
   parameter int              N_SLOTS     = 4,
   parameter int              ADDR_W      = 20,
   parameter bit              SLOT0_FIXED = 1'b1,
   parameter logic [ADDR_W-1:0] SLOT0_BASE  = '0,
   parameter logic [ADDR_W-1:0] SLOT0_MASK  = 20'hFFFC0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_W-1:0]    address,
   input  logic [3:0]           command,
   input  logic [3:0]           nibble_in,
   input  logic [4*N_SLOTS-1:0] dev_nibble_in,
   input  logic [N_SLOTS-1:0]   dev_err,
   input  logic [3:0]           rom_nibble_in,
   output logic [N_SLOTS-1:0]   dev_sel,
   output logic [3:0]           nibble_out,
   output logic                 bus_error,
   output logic                 cfg_done
);

   localparam bit CFG_DONE_RST = (N_SLOTS == 1) && SLOT0_FIXED;

   logic is_read, is_rw, is_cfg, is_reset;
   assign is_read  = (command == BUSCMD_PC_READ) || (command == BUSCMD_DP_READ);
   assign is_rw    = is_read || (command == BUSCMD_DP_WRITE);
   assign is_cfg   = (command == BUSCMD_CONFIGURE);
   assign is_reset = (command == BUSCMD_RESET);

   logic [N_SLOTS-1:0] configured;
   logic [N_SLOTS-1:0] hit;
   logic [N_SLOTS-1:0] cfg_wr;
   logic [N_SLOTS-1:0] ptr_oh;
   logic [N_SLOTS-1:0] win_oh;
   logic               pending;
   logic               any_hit;

   for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
      hp48_bus_slot #(
         .ADDR_W   (ADDR_W),
         .FIXED    ((i == 0) && SLOT0_FIXED),
         .FIX_BASE (SLOT0_BASE),
         .FIX_MASK (SLOT0_MASK)
      ) u_slot (
         .clk        (clk),
         .reset      (reset),
         .address    (address),
         .cfg_wr     (cfg_wr[i]),
         .bus_reset  (is_reset),
         .configured (configured[i]),
         .hit        (hit[i])
      );
   end

   // Config pointer and decode winner are both "lowest index first".
   always_comb begin
      ptr_oh  = '0;
      pending = 1'b0;
      win_oh  = '0;
      any_hit = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (!configured[i] && !pending) begin
            ptr_oh[i] = 1'b1;
            pending   = 1'b1;
         end
         if (hit[i] && !any_hit) begin
            win_oh[i] = 1'b1;
            any_hit   = 1'b1;
         end
      end
   end

   assign cfg_wr  = is_cfg ? ptr_oh : '0;
   assign dev_sel = is_rw ? win_oh : '0;

   logic [3:0] rd_dat;
   logic       win_err;
   logic       err_next;

   always_comb begin
      rd_dat  = 4'h0;
      win_err = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (win_oh[i]) begin
            rd_dat  = rd_dat | dev_nibble_in[4*i +: 4];
            win_err = win_err | dev_err[i];
         end
      end
      if (!any_hit) rd_dat = rom_nibble_in;
   end

   assign err_next = (is_rw && any_hit && win_err)
                   || ((command == BUSCMD_DP_WRITE) && !any_hit)
                   || (is_cfg && !pending);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         nibble_out <= 4'h0;
         bus_error  <= 1'b0;
         cfg_done   <= CFG_DONE_RST;
      end else begin
         nibble_out <= is_read ? rd_dat : 4'h0;
         bus_error  <= err_next;
         cfg_done   <= &configured;
      end
   end

endmodule

// File: tb/tb_hp48_bus_cfg_mux.sv
// Directed bench for hp48_bus_cfg_mux (4 slots, slot 0 fixed at 00000/FFFC0).
module tb_hp48_bus_cfg_mux;
   import hp48_bus_cfg_mux_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [19:0] address = '0;
   logic [3:0]  command = BUSCMD_NOP;
   logic [3:0]  nibble_in = 4'h0;
   logic [15:0] dev_nibble_in = 16'h43A1;
   logic [3:0]  dev_err = 4'h0;
   logic [3:0]  rom_nibble_in = 4'h5;
   logic [3:0]  dev_sel;
   logic [3:0]  nibble_out;
   logic        bus_error;
   logic        cfg_done;

   int checks = 0;
   int errors = 0;
   logic [3:0] sel_seen;

   hp48_bus_cfg_mux dut (
      .clk           (clk),
      .reset         (reset),
      .address       (address),
      .command       (command),
      .nibble_in     (nibble_in),
      .dev_nibble_in (dev_nibble_in),
      .dev_err       (dev_err),
      .rom_nibble_in (rom_nibble_in),
      .dev_sel       (dev_sel),
      .nibble_out    (nibble_out),
      .bus_error     (bus_error),
      .cfg_done      (cfg_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cmd;
      logic [19:0] addr;
      logic [3:0]  derr;
      logic [3:0]  rom;
      logic [3:0]  sel;
      logic [3:0]  nib;
      logic        err;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one command for one cycle; dev_sel is captured mid-cycle and the
   // registered outputs are left settled just after the edge.
   task automatic step(input logic [3:0] cmd, input logic [19:0] addr,
                       input logic [3:0] derr, input logic [3:0] rom);
      @(negedge clk);
      command       = cmd;
      address       = addr;
      dev_err       = derr;
      rom_nibble_in = rom;
      #1 sel_seen = dev_sel;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cycle(input string name, input logic [3:0] sel,
                               input logic [3:0] nib, input logic err);
      chk({name, ".sel"}, {28'h0, sel_seen}, {28'h0, sel});
      chk({name, ".nib"}, {28'h0, nibble_out}, {28'h0, nib});
      chk({name, ".err"}, {31'h0, bus_error}, {31'h0, err});
   endtask

   initial begin
      vecs[0]  = '{BUSCMD_DP_READ,  20'h80123, 4'h0, 4'h5, 4'b0010, 4'hA, 1'b0};
      vecs[1]  = '{BUSCMD_PC_READ,  20'h80150, 4'h0, 4'h5, 4'b0010, 4'hA, 1'b0};
      vecs[2]  = '{BUSCMD_DP_READ,  20'hC1234, 4'h0, 4'h5, 4'b1000, 4'h4, 1'b0};
      vecs[3]  = '{BUSCMD_DP_READ,  20'h00010, 4'h0, 4'h5, 4'b0001, 4'h1, 1'b0};
      vecs[4]  = '{BUSCMD_PC_READ,  20'h40000, 4'h0, 4'h5, 4'b0000, 4'h5, 1'b0};
      vecs[5]  = '{BUSCMD_DP_WRITE, 20'h40000, 4'h0, 4'h5, 4'b0000, 4'h0, 1'b1};
      vecs[6]  = '{BUSCMD_NOP,      20'h40000, 4'h0, 4'h5, 4'b0000, 4'h0, 1'b0};
      vecs[7]  = '{BUSCMD_DP_WRITE, 20'h80123, 4'h2, 4'h5, 4'b0010, 4'h0, 1'b1};
      vecs[8]  = '{BUSCMD_DP_READ,  20'hC0000, 4'h2, 4'h7, 4'b1000, 4'h4, 1'b0};
      vecs[9]  = '{BUSCMD_LOAD_DP,  20'h80123, 4'h0, 4'h5, 4'b0000, 4'h0, 1'b0};
      vecs[10] = '{BUSCMD_DP_READ,  20'h80123, 4'h2, 4'h5, 4'b0010, 4'hA, 1'b1};

      #1;
      chk("rst.nib", {28'h0, nibble_out}, 32'h0);
      chk("rst.err", {31'h0, bus_error}, 32'h0);
      chk("rst.cfg_done", {31'h0, cfg_done}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Slot 1: mask FF000, base 80000.
      step(BUSCMD_CONFIGURE, 20'hFF000, 4'h0, 4'h5);
      expect_cycle("cfg1a", 4'b0000, 4'h0, 1'b0);
      step(BUSCMD_CONFIGURE, 20'h80000, 4'h0, 4'h5);
      step(BUSCMD_DP_READ, 20'h80123, 4'h0, 4'h5);
      expect_cycle("first_read", 4'b0010, 4'hA, 1'b0);

      // Slot 2 overlaps slot 1 (80100/FFF00); slot 3 at C0000/F0000.
      step(BUSCMD_CONFIGURE, 20'hFFF00, 4'h0, 4'h5);
      step(BUSCMD_CONFIGURE, 20'h80100, 4'h0, 4'h5);
      step(BUSCMD_CONFIGURE, 20'hF0000, 4'h0, 4'h5);
      step(BUSCMD_CONFIGURE, 20'hC0000, 4'h0, 4'h5);
      step(BUSCMD_NOP, 20'h0, 4'h0, 4'h5);
      chk("cfg_done.full", {31'h0, cfg_done}, 32'h1);

      for (int i = 0; i < 11; i++) begin
         step(vecs[i].cmd, vecs[i].addr, vecs[i].derr, vecs[i].rom);
         expect_cycle($sformatf("vec%0d", i), vecs[i].sel, vecs[i].nib, vecs[i].err);
      end

      step(BUSCMD_CONFIGURE, 20'h12345, 4'h0, 4'h5);
      expect_cycle("overflow", 4'b0000, 4'h0, 1'b1);
      step(BUSCMD_DP_READ, 20'h80123, 4'h0, 4'h5);
      expect_cycle("post_overflow", 4'b0010, 4'hA, 1'b0);
      step(BUSCMD_DP_READ, 20'h12345, 4'h0, 4'h6);
      expect_cycle("overflow_nomap", 4'b0000, 4'h6, 1'b0);
      chk("cfg_done.kept", {31'h0, cfg_done}, 32'h1);

      step(BUSCMD_RESET, 20'h0, 4'h0, 4'h5);
      expect_cycle("busreset", 4'b0000, 4'h0, 1'b0);
      step(BUSCMD_DP_READ, 20'h80123, 4'h0, 4'h5);
      expect_cycle("busreset_miss", 4'b0000, 4'h5, 1'b0);
      chk("cfg_done.cleared", {31'h0, cfg_done}, 32'h0);
      step(BUSCMD_DP_READ, 20'hC0000, 4'h0, 4'h9);
      expect_cycle("busreset_miss3", 4'b0000, 4'h9, 1'b0);
      step(BUSCMD_DP_READ, 20'h00010, 4'h0, 4'h5);
      expect_cycle("fixed_survives", 4'b0001, 4'h1, 1'b0);

      // Re-config restarts at slot 1: 00000/F0000, overlapping fixed slot 0.
      step(BUSCMD_CONFIGURE, 20'hF0000, 4'h0, 4'h5);
      step(BUSCMD_CONFIGURE, 20'h00000, 4'h0, 4'h5);
      step(BUSCMD_DP_READ, 20'h00010, 4'h0, 4'h5);
      expect_cycle("prio_slot0", 4'b0001, 4'h1, 1'b0);
      step(BUSCMD_DP_READ, 20'h00100, 4'h0, 4'h5);
      expect_cycle("prio_slot1", 4'b0010, 4'hA, 1'b0);

      // Slot 2 sized with mask 0 would match everything if SIZED could hit.
      step(BUSCMD_CONFIGURE, 20'h00000, 4'h0, 4'h5);
      step(BUSCMD_DP_READ, 20'h40000, 4'h0, 4'h5);
      expect_cycle("sized_nohit", 4'b0000, 4'h5, 1'b0);

      step(BUSCMD_DP_READ, 20'h00100, 4'h2, 4'h5);
      expect_cycle("pre_arst", 4'b0010, 4'hA, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("arst.nib", {28'h0, nibble_out}, 32'h0);
      chk("arst.err", {31'h0, bus_error}, 32'h0);
      chk("arst.cfg_done", {31'h0, cfg_done}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      step(BUSCMD_DP_READ, 20'h00100, 4'h0, 4'h5);
      expect_cycle("arst_unmapped", 4'b0000, 4'h5, 1'b0);
      step(BUSCMD_CONFIGURE, 20'hFFF00, 4'h0, 4'h5);
      step(BUSCMD_CONFIGURE, 20'h80100, 4'h0, 4'h5);
      step(BUSCMD_DP_READ, 20'h80123, 4'h0, 4'h5);
      expect_cycle("arst_recfg_hit", 4'b0010, 4'hA, 1'b0);
      step(BUSCMD_DP_READ, 20'h80023, 4'h0, 4'h3);
      expect_cycle("arst_recfg_miss", 4'b0000, 4'h3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
